if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: takes a fetch address, issues a single-word memory
// read, and holds the returned instruction until the core consumes it.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00010000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_ren,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        inst_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] saved_r, saved_s;
  logic [31:0] inst_r, inst_s;
  logic [31:0] inst_pc_r, inst_pc_s;
  logic        inst_valid_r, inst_valid_s;
  logic        inst_err_r, inst_err_s;
  logic        acc_s;
  logic [31:0] acc_pc_s;

  function automatic logic is_misaligned(input logic [31:0] a);
    return (a[1:0] != 2'b00);
  endfunction

  // Handshake toward PC control and the memory request, both derived from state.
  always_comb begin
    pc_ready   = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && inst_ready);
    mem_ren    = (state_r == ST_REQ) || (state_r == ST_DRAIN);
    mem_addr   = addr_r[31:2];
    inst       = inst_r;
    inst_pc    = inst_pc_r;
    inst_valid = inst_valid_r;
    inst_err   = inst_err_r;
  end

  // Next-state logic; any accepted address (pc_in, redirect or saved target)
  // funnels through acc_s so aligned/misaligned handling lives in one place.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    saved_s      = saved_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    inst_valid_s = inst_valid_r;
    inst_err_s   = inst_err_r;
    acc_s        = 1'b0;
    acc_pc_s     = pc_in;

    case (state_r)
      ST_IDLE: begin
        if (redirect) begin
          acc_s    = 1'b1;
          acc_pc_s = redirect_pc;
        end else if (pc_valid) begin
          acc_s    = 1'b1;
          acc_pc_s = pc_in;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!mem_stall) begin
          if (redirect) begin
            acc_s    = 1'b1;
            acc_pc_s = redirect_pc;
          end else begin
            inst_s       = mem_rdata;
            inst_pc_s    = addr_r;
            inst_err_s   = 1'b0;
            inst_valid_s = 1'b1;
            state_s      = ST_HOLD;
          end
        end else if (redirect) begin
          saved_s = redirect_pc;
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          acc_s    = 1'b1;
          acc_pc_s = redirect_pc;
        end else if (inst_ready) begin
          if (pc_valid) begin
            acc_s    = 1'b1;
            acc_pc_s = pc_in;
          end else begin
            inst_valid_s = 1'b0;
            state_s      = ST_IDLE;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // The stale read must complete before the new target can be issued.
        if (!mem_stall) begin
          acc_s    = 1'b1;
          acc_pc_s = redirect ? redirect_pc : saved_r;
        end else if (redirect) begin
          saved_s = redirect_pc;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        inst_valid_s = 1'b0;
      end
    endcase

    if (acc_s) begin
      if (is_misaligned(acc_pc_s)) begin
        inst_s       = NOP_INST;
        inst_pc_s    = acc_pc_s;
        inst_err_s   = 1'b1;
        inst_valid_s = 1'b1;
        state_s      = ST_HOLD;
      end else begin
        addr_s       = acc_pc_s;
        inst_valid_s = 1'b0;
        state_s      = ST_REQ;
      end
    end else begin
      acc_pc_s = acc_pc_s;
    end
  end

  // State registers with synchronous reset that restarts fetch at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_REQ;
      addr_r       <= RESET_PC;
      saved_r      <= 32'h00000000;
      inst_r       <= NOP_INST;
      inst_pc_r    <= 32'h00000000;
      inst_valid_r <= 1'b0;
      inst_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      saved_r      <= saved_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      inst_valid_r <= inst_valid_s;
      inst_err_r   <= inst_err_s;
    end
  end

endmodule
